// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Provides the control FSM state encoding and the counter sizing helper.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // The counter holds WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_multi_module_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface seq_multi_module_if
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     out;
  logic                 ovf;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, out, ovf
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, out, ovf
  );

endinterface

// File: rtl/param_add_module.sv
// WIDTH-bit ripple-carry adder with carry in and carry out.
// Used for the per-iteration partial-product add of the multiplier.
module param_add_module #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multi_module.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned,
// with valid/ready handshakes on operand and result sides.
module seq_multi_module
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multi_module_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 neg;
  logic                 sgn;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]     out_q;
  logic                 ovf_q;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   result;
  logic                 ovf_next;

  // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign abs_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The multiplier lives in the low half of acc and is shifted out as product bits shift in,
  // so acc[0] is always the multiplier bit for the current iteration.
  assign add_b = acc[0] ? mcand : '0;

  param_add_module #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign acc_next = {cout, sum, acc[WIDTH-1:1]};
  assign result   = (sgn && neg) ? -acc_next : acc_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ovf_next = 1'b0;
    if (sgn) begin
      ovf_next = (|result[2*WIDTH-1:WIDTH-1]) && !(&result[2*WIDTH-1:WIDTH-1]);
    end else begin
      ovf_next = |result[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of its sources regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      acc         <= '0;
      count       <= '0;
      neg         <= 1'b0;
      sgn         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= abs_a;
            acc        <= {{WIDTH{1'b0}}, abs_b};
            neg        <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sgn        <= bus.signed_mode;
            count      <= CW'(WIDTH - 1);
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end

        CALC: begin
          acc   <= acc_next;
          count <= count - CW'(1);
          if (count == '0) begin
            product_q   <= result;
            out_q       <= result[WIDTH-1:0];
            ovf_q       <= ovf_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          // New operands presented alongside out_ready wait for the next edge in IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;

endmodule
